// File: rtl/loader_pkg.sv
// Shared types and constants for the loader/dump datapath.
// Holds the dump FSM encoding, the TX handshake sequencer encoding and the byte-order helper.
package loader_pkg;

  localparam logic [7:0] ACK_FINISH      = 8'hF1;
  localparam logic [7:0] DUMP_END_MARKER = 8'hF2;

  typedef enum logic [3:0] {
    StIdle,
    StSizeHi,
    StSizeLo,
    StTx,
    StMemReq,
    StMemWait,
    StMemLatch,
    StSendByte,
    StTrailer,
    StDone
  } dump_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxWait
  } tx_seq_state_e;

  // Words go out on the wire least-significant byte first.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/dump_unit_if.sv
// Arbiter, UART TX and memory-port signals of the dump engine.
// master is the dump engine side, slave is the surrounding system.
interface dump_unit_if;
  logic        grant_i;
  logic        target_select_i;
  logic [15:0] word_count_i;
  logic        done_o;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_done_i;
  logic        mem_read_enable_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        target_o;

  modport master (
    input  grant_i, target_select_i, word_count_i, tx_done_i, mem_data_i,
    output done_o, tx_data_o, tx_start_o, mem_read_enable_o, mem_addr_o, target_o
  );

  modport slave (
    output grant_i, target_select_i, word_count_i, tx_done_i, mem_data_i,
    input  done_o, tx_data_o, tx_start_o, mem_read_enable_o, mem_addr_o, target_o
  );
endinterface

// File: rtl/tx_byte_sequencer.sv
// Single-byte UART TX handshake: latch a byte, pulse start once, wait for done.
// ready_o is a one-cycle pulse coinciding with the accepted tx_done_i.
module tx_byte_sequencer
  import loader_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       abort_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  input  logic       tx_done_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       ready_o
);

  tx_seq_state_e state_q, state_d;
  logic [7:0]    data_q, data_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TxIdle;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    tx_start_o = 1'b0;
    ready_o    = 1'b0;
    case (state_q)
      TxIdle: begin
        if (load_i) begin
          data_d  = byte_i;
          state_d = TxStart;
        end
      end
      TxStart: begin
        tx_start_o = 1'b1;
        state_d    = TxWait;
      end
      TxWait: begin
        if (tx_done_i) begin
          ready_o = 1'b1;
          state_d = TxIdle;
        end
      end
      default: state_d = TxIdle;
    endcase
    // Data is left in place on abort; the UART may still be shifting it out.
    if (abort_i) begin
      state_d = TxIdle;
    end
  end

  assign tx_data_o = data_q;

endmodule

// File: rtl/dump_unit.sv
// DMA memory-extraction engine: streams a 16-bit big-endian word count, N memory words
// (LSB first) and an end marker to the UART TX while it holds the arbiter grant.
module dump_unit
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [7:0]  END_MARKER = DUMP_END_MARKER
) (
  input logic         clk_i,
  input logic         rst_i,
  dump_unit_if.master bus
);

  dump_state_e state_q, state_d;
  dump_state_e ret_q, ret_d;
  logic [15:0] count_q, count_d;
  logic [15:0] remaining_q, remaining_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic        target_q, target_d;

  logic        seq_load;
  logic [7:0]  seq_byte;
  logic        seq_ready;
  logic        abort;

  // Losing the grant anywhere between idle and done drops the transfer.
  assign abort = !bus.grant_i && (state_q != StIdle) && (state_q != StDone);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ret_q       <= StIdle;
      count_q     <= 16'h0000;
      remaining_q <= 16'h0000;
      addr_q      <= BASE_ADDR;
      word_q      <= 32'h0000_0000;
      idx_q       <= 2'd0;
      target_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      target_q    <= target_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    word_d      = word_q;
    idx_d       = idx_q;
    target_d    = target_q;
    seq_load    = 1'b0;
    seq_byte    = 8'h00;

    case (state_q)
      StIdle: begin
        addr_d = BASE_ADDR;
        if (bus.grant_i) begin
          count_d     = bus.word_count_i;
          remaining_d = bus.word_count_i;
          target_d    = bus.target_select_i;
          idx_d       = 2'd0;
          state_d     = StSizeHi;
        end
      end
      StSizeHi: begin
        seq_load = 1'b1;
        seq_byte = count_q[15:8];
        ret_d    = StSizeLo;
        state_d  = StTx;
      end
      StSizeLo: begin
        seq_load = 1'b1;
        seq_byte = count_q[7:0];
        ret_d    = (remaining_q == 16'h0000) ? StTrailer : StMemReq;
        state_d  = StTx;
      end
      StTx: begin
        if (seq_ready) begin
          if (ret_q == StSendByte) begin
            // Payload byte finished: step to the next byte or the next word.
            if (idx_q == 2'd3) begin
              addr_d      = addr_q + 32'd4;
              remaining_d = remaining_q - 16'd1;
              state_d     = (remaining_q != 16'd1) ? StMemReq : StTrailer;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = StSendByte;
            end
          end else begin
            state_d = ret_q;
          end
        end
      end
      StMemReq:  state_d = StMemWait;
      StMemWait: state_d = StMemLatch;
      StMemLatch: begin
        word_d  = bus.mem_data_i;
        idx_d   = 2'd0;
        state_d = StSendByte;
      end
      StSendByte: begin
        seq_load = 1'b1;
        seq_byte = word_byte(word_q, idx_q);
        ret_d    = StSendByte;
        state_d  = StTx;
      end
      StTrailer: begin
        seq_load = 1'b1;
        seq_byte = END_MARKER;
        ret_d    = StDone;
        state_d  = StTx;
      end
      StDone: begin
        if (!bus.grant_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d  = StIdle;
      addr_d   = BASE_ADDR;
      seq_load = 1'b0;
    end
  end

  tx_byte_sequencer u_tx_seq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .abort_i    (abort),
    .load_i     (seq_load),
    .byte_i     (seq_byte),
    .tx_done_i  (bus.tx_done_i),
    .tx_start_o (bus.tx_start_o),
    .tx_data_o  (bus.tx_data_o),
    .ready_o    (seq_ready)
  );

  assign bus.done_o            = (state_q == StDone);
  assign bus.mem_read_enable_o = (state_q == StMemReq);
  assign bus.mem_addr_o        = addr_q;
  assign bus.target_o          = target_q;

endmodule
